// File: rtl/muller_c_pkg.sv
// Shared definitions for the Muller C-element handshake driver.
// Holds default widths, FSM state encodings and the error-code values
// reported on err_code_o.
package muller_c_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int SKEW_W_DEF = 4;
    localparam int TMO_W_DEF  = 8;

    // Plain vector encoding keeps the state register readable by older tools.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RISE    = 3'd1;
    localparam state_t ST_WAIT_HI = 3'd2;
    localparam state_t ST_FALL    = 3'd3;
    localparam state_t ST_WAIT_LO = 3'd4;
    localparam state_t ST_DONE    = 3'd5;
    localparam state_t ST_ERR     = 3'd6;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_TMO_HI = 2'b01;
    localparam logic [1:0] ERR_TMO_LO = 2'b10;
    localparam logic [1:0] ERR_EARLY  = 2'b11;

endpackage

// File: rtl/muller_c_hs_driver_if.sv
// Link between the handshake driver and the C-element under test.
//   a_o       : C-element input A (driver -> C-element)
//   b_o       : C-element input B (driver -> C-element)
//   c_async_i : C-element output, asynchronous to the driver clock
// master = driver side, slave = C-element side.
interface muller_c_hs_driver_if;

    logic a_o;
    logic b_o;
    logic c_async_i;

    modport master (output a_o, output b_o, input c_async_i);
    modport slave  (input a_o, input b_o, output c_async_i);

endinterface

// File: rtl/muller_c_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the
// clk domain. Synchronous active-low reset clears both stages.
//   clk, rst_n : clock and synchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output, two cycles of latency
module muller_c_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample the pre-edge values and form a true two-stage shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/muller_c_hs_driver.sv
// Four-phase handshake driver for exercising a Muller C-element.
// Raises A then B (B lagging by skew cycles), waits for the synchronized
// C output to rise, lowers A then B, waits for C to fall, and repeats for
// the requested number of handshakes. Flags timeouts and C transitions
// that occur before both inputs have moved.
//   clk, rst_n   : clock, synchronous active-low reset
//   start_i      : one-cycle launch pulse, honoured only when idle
//   cycles_i     : handshakes to perform (0 = finish immediately)
//   skew_i       : cycles from an A edge to the matching B edge
//   timeout_i    : max cycles to wait for C per phase, 0 = no limit
//   cel          : C-element link (a_o, b_o out; c_async_i in)
//   busy_o       : run in progress
//   done_o       : one-cycle pulse on successful completion
//   err_o        : sticky error flag, err_code_o gives the cause
//   count_o      : completed handshakes of the current or last run
module muller_c_hs_driver
    import muller_c_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SKEW_W = SKEW_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     cycles_i,
    input  logic [SKEW_W-1:0]    skew_i,
    input  logic [TMO_W-1:0]     timeout_i,
    muller_c_hs_driver_if.master cel,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic [CNT_W-1:0]     count_o
);

    logic c_s;

    muller_c_sync2 #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cel.c_async_i),
        .q_o   (c_s)
    );

    state_t             state_q,    state_d;
    logic               a_q,        a_d;
    logic               b_q,        b_d;
    logic [CNT_W-1:0]   cycles_q,   cycles_d;
    logic [SKEW_W-1:0]  skew_q,     skew_d;
    logic [TMO_W-1:0]   tmo_q,      tmo_d;
    logic [SKEW_W-1:0]  skew_cnt_q, skew_cnt_d;
    // One bit wider than timeout_i so an all-ones limit is still reachable.
    logic [TMO_W:0]     timer_q,    timer_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               err_q,      err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [CNT_W-1:0]   count_inc;
    logic               tmo_hit;

    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
    assign tmo_hit   = (tmo_q != '0) && (timer_q == {1'b0, tmo_q});

    always_comb begin
        // NOTE: every combinational output takes its hold value first so no
        // path through the case leaves it unassigned and infers a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cycles_d   = cycles_q;
        skew_d     = skew_q;
        tmo_d      = tmo_q;
        skew_cnt_d = skew_cnt_q;
        timer_d    = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cycles_d   = cycles_i;
                    skew_d     = skew_i;
                    tmo_d      = timeout_i;
                    count_d    = '0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    if (cycles_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_RISE;
                        a_d        = 1'b1;
                        b_d        = (skew_i == '0);
                        skew_cnt_d = '0;
                    end
                end
            end

            ST_RISE: begin
                if (b_q) begin
                    state_d = ST_WAIT_HI;
                    timer_d = '0;
                end else if (c_s) begin
                    // C rose on A alone: the element is not acting as a C-element.
                    state_d    = ST_ERR;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_EARLY;
                end else begin
                    skew_cnt_d = skew_cnt_q + 1'b1;
                    if (skew_cnt_d == skew_q) begin
                        b_d     = 1'b1;
                        state_d = ST_WAIT_HI;
                        timer_d = '0;
                    end
                end
            end

            ST_WAIT_HI: begin
                if (c_s) begin
                    state_d    = ST_FALL;
                    a_d        = 1'b0;
                    b_d        = (skew_q != '0);
                    skew_cnt_d = '0;
                end else if (tmo_hit) begin
                    state_d    = ST_ERR;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO_HI;
                end
            end

            ST_FALL: begin
                if (!b_q) begin
                    state_d = ST_WAIT_LO;
                    timer_d = '0;
                end else if (!c_s) begin
                    state_d    = ST_ERR;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_EARLY;
                end else begin
                    skew_cnt_d = skew_cnt_q + 1'b1;
                    if (skew_cnt_d == skew_q) begin
                        b_d     = 1'b0;
                        state_d = ST_WAIT_LO;
                        timer_d = '0;
                    end
                end
            end

            ST_WAIT_LO: begin
                if (!c_s) begin
                    count_d = count_inc;
                    if (count_inc == cycles_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_RISE;
                        a_d        = 1'b1;
                        b_d        = (skew_q == '0);
                        skew_cnt_d = '0;
                    end
                end else if (tmo_hit) begin
                    state_d    = ST_ERR;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO_LO;
                end
            end

            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;

            default: begin
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: every flop, including latched run configuration, is reset so
        // a mid-run reset leaves no stale state behind.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            cycles_q   <= '0;
            skew_q     <= '0;
            tmo_q      <= '0;
            skew_cnt_q <= '0;
            timer_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cycles_q   <= cycles_d;
            skew_q     <= skew_d;
            tmo_q      <= tmo_d;
            skew_cnt_q <= skew_cnt_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign cel.a_o    = a_q;
    assign cel.b_o    = b_q;
    assign busy_o     = (state_q == ST_RISE)    || (state_q == ST_WAIT_HI) ||
                        (state_q == ST_FALL)    || (state_q == ST_WAIT_LO);
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_muller_c_hs_driver.sv
// Self-checking bench for muller_c_hs_driver. A behavioural C-element with
// one cycle of delay closes the loop; it can also be forced stuck-at-0 or
// to follow A alone. Each launched run pushes its expected outcome to a
// scoreboard queue; a negedge monitor pops it when done_o pulses or err_o
// rises and compares the end state plus A/B edge counts and B-after-A lag.
module tb_muller_c_hs_driver;

    localparam int CNT_W  = 8;
    localparam int SKEW_W = 4;
    localparam int TMO_W  = 8;
    localparam int C_DLY  = 1;

    typedef struct {
        int         cycles;
        int         skew;
        logic       err;
        logic [1:0] code;
        int         count;
        int         a_rises;
        int         b_rises;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [CNT_W-1:0]  cycles_i;
    logic [SKEW_W-1:0] skew_i;
    logic [TMO_W-1:0]  timeout_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [1:0]        err_code_o;
    logic [CNT_W-1:0]  count_o;

    muller_c_hs_driver_if hs();

    muller_c_hs_driver #(.CNT_W(CNT_W), .SKEW_W(SKEW_W), .TMO_W(TMO_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .cycles_i   (cycles_i),
        .skew_i     (skew_i),
        .timeout_i  (timeout_i),
        .cel        (hs.master),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // C-element model: 0 = correct, 1 = stuck at 0, 2 = follows A only.
    int         c_mode = 0;
    logic [3:0] c_pipe = '0;

    always @(posedge clk) begin
        if (c_mode == 1)
            c_pipe[0] <= 1'b0;
        else if (c_mode == 2)
            c_pipe[0] <= hs.a_o;
        else if (hs.a_o && hs.b_o)
            c_pipe[0] <= 1'b1;
        else if (!hs.a_o && !hs.b_o)
            c_pipe[0] <= 1'b0;
        c_pipe[3:1] <= c_pipe[2:0];
    end

    assign hs.c_async_i = c_pipe[C_DLY-1];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic a_prev = 1'b0, b_prev = 1'b0, err_prev = 1'b0;
    int   a_rises = 0, b_rises = 0, a_rise_cyc = 0;
    int   start_cyc = 0, st_cycles = 0;
    bit   post_start = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (post_start && cyc == start_cyc + 1) begin
                post_start = 1'b0;
                check("start_busy", busy_o, st_cycles != 0);
                check("start_err_clr", err_o, 0);
                check("start_code_clr", err_code_o, 0);
                if (st_cycles == 0)
                    check("zero_cycles_done_lat", done_o, 1);
            end
            if (start_i && !busy_o) begin
                a_rises    = 0;
                b_rises    = 0;
                start_cyc  = cyc;
                st_cycles  = int'(cycles_i);
                post_start = 1'b1;
            end
            if (hs.a_o && !a_prev) begin
                a_rises++;
                a_rise_cyc = cyc;
            end
            if (hs.b_o && !b_prev) begin
                b_rises++;
                if (sb_q.size() != 0)
                    check("b_lag", cyc - a_rise_cyc, sb_q[0].skew);
            end
            if (done_o || (err_o && !err_prev)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_end", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("end_done", done_o, !mon_e.err);
                    check("end_err", err_o, mon_e.err);
                    check("end_code", err_code_o, mon_e.code);
                    check("end_count", count_o, mon_e.count);
                    check("end_busy", busy_o, 0);
                    check("end_a", hs.a_o, 0);
                    check("end_b", hs.b_o, 0);
                    check("a_rises", a_rises, mon_e.a_rises);
                    check("b_rises", b_rises, mon_e.b_rises);
                end
            end
        end
        a_prev   = hs.a_o;
        b_prev   = hs.b_o;
        err_prev = err_o;
    end

    // ---------------- stimulus ----------------
    task automatic launch(input int cyc_n, input int skw, input int tmo,
                          input bit push, input exp_t e);
        @(posedge clk);
        #1;
        cycles_i  = CNT_W'(cyc_n);
        skew_i    = SKEW_W'(skw);
        timeout_i = TMO_W'(tmo);
        start_i   = 1'b1;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("run_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic exp_t mk(input int cyc_n, input int skw, input logic err,
                                input logic [1:0] code, input int cnt,
                                input int ar, input int br);
        exp_t e;
        e.cycles = cyc_n; e.skew = skw; e.err = err; e.code = code;
        e.count = cnt; e.a_rises = ar; e.b_rises = br;
        return e;
    endfunction

    initial begin
        exp_t none;
        none      = mk(0, 0, 1'b0, 2'b00, 0, 0, 0);
        rst_n     = 1'b0;
        start_i   = 1'b0;
        cycles_i  = '0;
        skew_i    = '0;
        timeout_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a", hs.a_o, 0);
        check("rst_b", hs.b_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_count", count_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: three handshakes, skew 2, no timeout
        launch(3, 2, 0, 1'b1, mk(3, 2, 1'b0, 2'b00, 3, 3, 3));
        wait_run();

        // T2: zero handshakes
        launch(0, 3, 0, 1'b1, mk(0, 3, 1'b0, 2'b00, 0, 0, 0));
        wait_run();

        // T3: C stuck low, timeout while waiting for rise
        c_mode = 1;
        launch(5, 1, 4, 1'b1, mk(5, 1, 1'b1, 2'b01, 0, 1, 1));
        wait_run();
        repeat (4) @(negedge clk);
        check("err_sticky", err_o, 1);
        check("err_code_sticky", err_code_o, 2'b01);

        // T6a: new start after an error clears the flag and runs cleanly
        c_mode = 0;
        launch(1, 0, 0, 1'b1, mk(1, 0, 1'b0, 2'b00, 1, 1, 1));
        wait_run();

        // T4: broken C-element follows A alone, wide skew
        c_mode = 2;
        launch(2, 6, 0, 1'b1, mk(2, 6, 1'b1, 2'b11, 0, 1, 0));
        wait_run();
        c_mode = 0;
        repeat (4) @(negedge clk);

        // T5: reset while parked in WAIT_HI
        c_mode = 1;
        launch(4, 1, 0, 1'b0, none);
        for (int i = 0; i < 100 && !hs.b_o; i++) @(negedge clk);
        check("t5_b_high", hs.b_o, 1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_rst_a", hs.a_o, 0);
        check("t5_rst_b", hs.b_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_done", done_o, 0);
        check("t5_rst_err", err_o, 0);
        check("t5_rst_count", count_o, 0);
        c_mode = 0;
        repeat (4) @(negedge clk);
        launch(2, 0, 10, 1'b1, mk(2, 0, 1'b0, 2'b00, 2, 2, 2));
        wait_run();

        // T6: start pulsed while busy is ignored
        launch(3, 1, 0, 1'b1, mk(3, 1, 1'b0, 2'b00, 3, 3, 3));
        repeat (4) @(posedge clk);
        #1;
        cycles_i = 8'd7;
        skew_i   = 4'd0;
        start_i  = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_run();
        check("t6_no_restart", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
